// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Waveform one-hot codes, key-filter state encoding and the
//               lowest-index priority encoder used by wave_sel_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    localparam logic [3:0] WAVE_SINE   = 4'b0001;
    localparam logic [3:0] WAVE_SQUARE = 4'b0010;
    localparam logic [3:0] WAVE_TRI    = 4'b0100;
    localparam logic [3:0] WAVE_SAW    = 4'b1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } filt_state_t;

    // Lowest asserted bit wins; callers only use the result when v != 0.
    function automatic logic [3:0] lowest_onehot(input logic [3:0] v);
        logic [3:0] w_res;
        casez (v)
            4'b???1: w_res = WAVE_SINE;
            4'b??10: w_res = WAVE_SQUARE;
            4'b?100: w_res = WAVE_TRI;
            4'b1000: w_res = WAVE_SAW;
            default: w_res = 4'b0000;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_filter.sv
`default_nettype none
// ============================================================================
// Module      : key_filter
// Description : 2-FF synchroniser plus debounce FSM for one active-low key;
//               emits a single-cycle key_flag on each confirmed press.
// Revision    : 1.0 - initial release
// ============================================================================
module key_filter
    import dds_pkg::*;
#(
    parameter int CNT_MAX = 1_000_000
)
(
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_flag
);

    localparam int                 c_CNT_W    = $clog2(CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CNT_MAX - 1);

    logic               r_key_s1;
    logic               r_key_s2;
    filt_state_t        r_state;
    filt_state_t        w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_flag;
    logic               w_flag_nxt;

    // Synchronisers reset to "released" so a held key is re-debounced after reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_flag   <= 1'b0;
        end else begin
            r_key_s1 <= key_in;
            r_key_s2 <= r_key_s1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_flag   <= w_flag_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flag_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_key_s2) begin
                    w_state_nxt = FILT_DN;
                    w_cnt_nxt   = '0;
                end
            end
            FILT_DN: begin
                if (r_key_s2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = DOWN;
                    w_flag_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DOWN: begin
                if (r_key_s2) begin
                    w_state_nxt = FILT_UP;
                    w_cnt_nxt   = '0;
                end
            end
            FILT_UP: begin
                // A re-press during release filtering returns to DOWN silently.
                if (!r_key_s2) begin
                    w_state_nxt = DOWN;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign key_flag = r_flag;

endmodule
`default_nettype wire

// File: rtl/wave_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wave_sel_ctrl
// Description : Four debounced push-buttons to a registered one-hot waveform
//               select; lowest-index confirmed press wins.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_sel_ctrl
    import dds_pkg::*;
#(
    parameter int CNT_MAX = 1_000_000
)
(
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] key_in,
    output logic [3:0] key_flag,
    output logic [3:0] wave_sel
);

    logic [3:0] r_wave_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            key_filter #(
                .CNT_MAX (CNT_MAX)
            ) u_key_filter (
                .sys_clk  (sys_clk),
                .sys_rst  (sys_rst),
                .key_in   (key_in[gi]),
                .key_flag (key_flag[gi])
            );
        end
    endgenerate

    // Holds its value between presses, so it stays one-hot after reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wave_sel <= WAVE_SINE;
        end else if (|key_flag) begin
            r_wave_sel <= lowest_onehot(key_flag);
        end
    end

    assign wave_sel = r_wave_sel;

endmodule
`default_nettype wire

// File: tb/tb_wave_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_sel_ctrl
// Description : Self-checking bench for wave_sel_ctrl with CNT_MAX = 10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_sel_ctrl;

    localparam int CNT_MAX = 10;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] key_in  = 4'hF;
    logic [3:0] key_flag;
    logic [3:0] wave_sel;

    wave_sel_ctrl #(
        .CNT_MAX (CNT_MAX)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key_in   (key_in),
        .key_flag (key_flag),
        .wave_sel (wave_sel)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int ftot     = 0;

    typedef struct {
        int         at;
        logic [3:0] flag;
        logic [3:0] sel;
        string      tag;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [3:0] keys;
        int         hold;
        logic [3:0] flag;
        logic [3:0] sel;
        int         pulses;
    } vec_t;

    vec_t vt[10];

    task automatic chk4(input string tag, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic chki(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push_exp(input int at, input logic [3:0] flag, input logic [3:0] sel,
                            input string tag);
        exp_t e;
        e.at   = at;
        e.flag = flag;
        e.sel  = sel;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // One clock: sample at the falling edge, retire due expectations, then
    // leave the caller 1 time unit past the edge to drive inputs.
    task automatic step();
        exp_t e;
        @(negedge sys_clk);
        for (int i = 0; i < 4; i++) ftot += int'(key_flag[i]);
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: expectation for cycle %0d missed at %0d", e.tag, e.at, cyc);
            end else begin
                chk4({e.tag, " flag"}, key_flag, e.flag);
                chk4({e.tag, " sel"}, wave_sel, e.sel);
            end
        end
        #1;
    endtask

    // Drive a key pattern; edge 0 is the next rising edge.
    task automatic press(input string tag, input logic [3:0] keys, input int hold,
                         input logic [3:0] exp_flag, input logic [3:0] prev_sel,
                         input logic [3:0] new_sel, input int pulses);
        int base;
        int f0;
        key_in = keys;
        base   = cyc + 1;
        f0     = ftot;
        push_exp(base + CNT_MAX + 1, 4'b0000,  prev_sel, {tag, "@11"});
        push_exp(base + CNT_MAX + 2, exp_flag, prev_sel, {tag, "@12"});
        push_exp(base + CNT_MAX + 3, 4'b0000,  new_sel,  {tag, "@13"});
        repeat (hold) step();
        chki({tag, " pulses"}, ftot - f0, pulses);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         f0;
        logic [3:0] cur_sel;

        vt[0] = '{4'b1011, 50, 4'b0100, 4'b0100, 1};
        vt[1] = '{4'b1111, 30, 4'b0000, 4'b0100, 0};
        vt[2] = '{4'b0101, 30, 4'b1010, 4'b0010, 2};
        vt[3] = '{4'b1111, 30, 4'b0000, 4'b0010, 0};
        vt[4] = '{4'b0111, 30, 4'b1000, 4'b1000, 1};
        vt[5] = '{4'b1111, 30, 4'b0000, 4'b1000, 0};
        vt[6] = '{4'b1110, 30, 4'b0001, 4'b0001, 1};
        vt[7] = '{4'b1111, 30, 4'b0000, 4'b0001, 0};
        vt[8] = '{4'b1101, 30, 4'b0010, 4'b0010, 1};
        vt[9] = '{4'b1111, 30, 4'b0000, 4'b0010, 0};

        // Power-on reset
        repeat (3) step();
        chk4("por flag", key_flag, 4'b0000);
        chk4("por sel", wave_sel, 4'b0001);
        sys_rst = 1'b0;
        repeat (3) step();
        chk4("post-por flag", key_flag, 4'b0000);
        chk4("post-por sel", wave_sel, 4'b0001);

        cur_sel = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            press($sformatf("vec%0d", i), vt[i].keys, vt[i].hold, vt[i].flag,
                  cur_sel, vt[i].sel, vt[i].pulses);
            cur_sel = vt[i].sel;
        end

        // Reset while a flag is high: flag clears and sel returns to sine at once
        key_in = 4'b0111;
        base   = cyc + 1;
        while (cyc < base + CNT_MAX + 2) step();
        chk4("pre-reset flag", key_flag, 4'b1000);
        #2;
        sys_rst = 1'b1;
        #1;
        chk4("async reset flag", key_flag, 4'b0000);
        chk4("async reset sel", wave_sel, 4'b0001);
        key_in = 4'b1111;
        repeat (2) step();
        sys_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk4("idle after reset flag", key_flag, 4'b0000);
            chk4("idle after reset sel", wave_sel, 4'b0001);
        end

        // Bouncing key 1 never confirms
        f0 = ftot;
        for (int i = 0; i < 40; i++) begin
            key_in = (((i / 3) % 2) == 0) ? 4'b1101 : 4'b1111;
            step();
        end
        key_in = 4'b1111;
        repeat (20) step();
        chki("bounce pulses", ftot - f0, 0);
        chk4("bounce sel", wave_sel, 4'b0001);
        press("bounce_stable", 4'b1101, 20, 4'b0010, 4'b0001, 4'b0010, 1);
        key_in = 4'b1111;
        repeat (25) step();

        // Release glitch on key 3 emits no flag; a later full re-press does
        press("rel_press", 4'b0111, 20, 4'b1000, 4'b0010, 4'b1000, 1);
        key_in = 4'b1111;
        f0 = ftot;
        repeat (5) step();
        key_in = 4'b0111;
        step();
        key_in = 4'b1111;
        repeat (25) step();
        chki("release glitch pulses", ftot - f0, 0);
        chk4("release glitch sel", wave_sel, 4'b1000);
        press("re_press", 4'b0111, 20, 4'b1000, 4'b1000, 4'b1000, 1);
        key_in = 4'b1111;
        repeat (25) step();

        // Reset mid-filter: held key 0 must be debounced afresh
        key_in = 4'b1110;
        f0 = ftot;
        repeat (8) step();
        chki("mid-filter pre-reset pulses", ftot - f0, 0);
        sys_rst = 1'b1;
        step();
        chk4("mid-filter reset sel", wave_sel, 4'b0001);
        sys_rst = 1'b0;
        base = cyc + 1;
        f0   = ftot;
        push_exp(base + CNT_MAX + 1, 4'b0000, 4'b0001, "rst_filt@11");
        push_exp(base + CNT_MAX + 2, 4'b0001, 4'b0001, "rst_filt@12");
        push_exp(base + CNT_MAX + 3, 4'b0000, 4'b0001, "rst_filt@13");
        repeat (25) step();
        chki("rst_filt pulses", ftot - f0, 1);
        key_in = 4'b1111;
        repeat (5) step();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
